shift_deser: RTL and testbench



---
 rtl/shift_pkg.sv | 15 +
 rtl/deser_hold_reg.sv | 46 ++++
 rtl/shift_deser.sv | 140 ++++++++++++++
 tb/tb_shift_deser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial-to-parallel receive path.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } deser_state_t;

    // Bit count needed to hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// Single-entry valid/ready holding register for assembled words.
// A word offered while the entry is full and not being drained is dropped
// and raises the sticky ovf flag. A new overflow takes priority over ovf_clr.
module deser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_rdy,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    output logic             ovf
);

    logic accept;
    logic drop;

    assign accept = load_req & (~out_vld | out_rdy);
    assign drop   = load_req & out_vld & ~out_rdy;

    // Holding register, valid flag and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                out_data <= load_data;
                out_vld  <= 1'b1;
            end else if (out_vld && out_rdy) begin
                out_vld  <= 1'b0;
            end

            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: aligns on in_sof, assembles WIDTH-bit words
// and hands them to a valid/ready holding register.
// Optional even-parity bit after each word: define SHIFT_DESER_PARITY_EN.
//
//   state | meaning
//   IDLE  | unaligned, waiting for a strobed sof bit
//   SHIFT | accumulating data bits, cnt = bits received so far
//   PAR   | word complete, waiting for its parity bit (parity builds only)
module shift_deser
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    input  logic             in_bit,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             par_err
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
`ifdef SHIFT_DESER_PARITY_EN
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
`endif

    deser_state_t     state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] acc_sof;
    logic             load_req;
    logic [WIDTH-1:0] load_data;
`ifdef SHIFT_DESER_PARITY_EN
    logic             par_err_nxt;
`endif

    // The sof bit is placed so that WIDTH-1 further shifts move it to the
    // word's first-bit position.
    assign acc_shift = MSB_FIRST ? {acc[WIDTH-2:0], in_bit} : {in_bit, acc[WIDTH-1:1]};
    assign acc_sof   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, in_bit} : {in_bit, {(WIDTH-1){1'b0}}};

    // State, bit counter and accumulator registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    // Next-state, accumulation and delivery request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        load_req  = 1'b0;
        load_data = acc_shift;
`ifdef SHIFT_DESER_PARITY_EN
        par_err_nxt = 1'b0;
`endif
        if (in_vld) begin
            if (in_sof) begin
                // sof always restarts a word, discarding any partial one
                acc_nxt   = acc_sof;
                cnt_nxt   = CW'(1);
                state_nxt = SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        acc_nxt = acc_shift;
                        if (cnt == CNT_LAST) begin
`ifdef SHIFT_DESER_PARITY_EN
                            cnt_nxt   = CNT_FULL;
                            state_nxt = PAR;
`else
                            load_req  = 1'b1;
                            cnt_nxt   = '0;
`endif
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
`ifdef SHIFT_DESER_PARITY_EN
                    PAR: begin
                        cnt_nxt   = '0;
                        state_nxt = SHIFT;
                        load_data = acc;
                        if (in_bit == ^acc) begin
                            load_req = 1'b1;
                        end else begin
                            par_err_nxt = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    // One-cycle parity error pulse, aligned with the would-be delivery.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_nxt;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    deser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rstn      (rstn),
        .load_req  (load_req),
        .load_data (load_data),
        .out_rdy   (out_rdy),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (WIDTH=8, MSB first).
// Builds with or without SHIFT_DESER_PARITY_EN.
module tb_shift_deser;

`ifdef SHIFT_DESER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic       par_err;

    int errors = 0;
    int checks = 0;

    shift_deser #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (in_vld),
        .in_bit   (in_bit),
        .in_sof   (in_sof),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit; returns 1 ns after the sampling edge.
    task automatic send_bit(input logic b, input logic sof);
        @(negedge clk);
        in_vld = 1'b1;
        in_bit = b;
        in_sof = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        @(negedge clk);
        in_vld = 1'b0;
        in_sof = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full frame MSB first (plus even parity when compiled in); optionally raise
    // out_rdy / ovf_clr for the final strobe edge only.
    task automatic send_frame(input logic [7:0] d, input bit sof, input bit rdy_last, input bit clr_last);
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) begin
                if (rdy_last) out_rdy = 1'b1;
                if (clr_last) ovf_clr = 1'b1;
            end
            b = (i < 8) ? d[7 - i] : ^d;
            send_bit(b, sof && (i == 0));
        end
        ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_par_err", par_err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic word A5, out_rdy=1: valid for exactly one cycle after final strobe
        out_rdy = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < NB - 1; i++) send_bit((i < 8) ? w[7 - i] : ^w, i == 0);
        chk("a5_not_early", out_vld, 1'b0);
        send_bit((NB == 9) ? ^w : w[0], 1'b0);
        chk("a5_vld", out_vld, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        quiet();
        chk("a5_vld_drop", out_vld, 1'b0);

        // Overflow with out_rdy=0: held word stays, ovf set, ovf_clr clears
        out_rdy = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("ovf_hold_data", out_data, 8'hA5);
        chk("ovf_hold_vld", out_vld, 1'b1);
        chk("ovf_set", ovf, 1'b1);
        ovf_clr = 1'b1;
        quiet();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 1'b0);

        // New overflow on the same edge as ovf_clr: overflow wins
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("ovf_wins_clr", ovf, 1'b1);
        chk("ovf_wins_data", out_data, 8'hA5);
        ovf_clr = 1'b1;
        quiet();
        ovf_clr = 1'b0;
        chk("ovf_clr2", ovf, 1'b0);
        out_rdy = 1'b1;
        quiet();
        chk("drain_vld", out_vld, 1'b0);

        // Resync: 3 bits after sof, then a fresh sof with 3C
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk("resync_vld", out_vld, 1'b1);
        chk("resync_data", out_data, 8'h3C);
        chk("resync_ovf", ovf, 1'b0);
        quiet();
        chk("resync_drain", out_vld, 1'b0);

        // Held word replaced on the edge out_rdy drains it
        out_rdy = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("swap_vld", out_vld, 1'b1);
        chk("swap_data", out_data, 8'h3C);
        chk("swap_ovf", ovf, 1'b0);
        quiet();
        chk("swap_drain", out_vld, 1'b0);

        // in_vld=0 gap mid-word holds accumulation
        w = 8'h96;
        for (int i = 0; i < NB; i++) begin
            if (i == 4) repeat (5) quiet();
            send_bit((i < 8) ? w[7 - i] : ^w, i == 0);
        end
        chk("gap_vld", out_vld, 1'b1);
        chk("gap_data", out_data, 8'h96);
        quiet();

        // Async reset mid-word with a held word pending
        out_rdy = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        in_vld = 1'b0;
        rstn = 1'b0;
        #1;
        chk("arst_data", out_data, 8'h00);
        chk("arst_vld", out_vld, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_par_err", par_err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < NB; i++) send_bit(1'b1, 1'b0);
        chk("nosof_vld", out_vld, 1'b0);
        quiet();
        chk("nosof_vld2", out_vld, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
        // Parity: good parity delivers, bad parity pulses par_err only
        w = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(w[7 - i], i == 0);
        chk("par_wait", out_vld, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("par_ok_vld", out_vld, 1'b1);
        chk("par_ok_data", out_data, 8'hA5);
        chk("par_ok_err", par_err, 1'b0);
        quiet();
        for (int i = 0; i < 8; i++) send_bit(w[7 - i], i == 0);
        send_bit(1'b1, 1'b0);
        chk("par_bad_err", par_err, 1'b1);
        chk("par_bad_vld", out_vld, 1'b0);
        chk("par_bad_ovf", ovf, 1'b0);
        quiet();
        chk("par_err_pulse", par_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
